// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag layout for the accumulating ALU pipeline.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_ONES = 3'b111;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    // A zeroed result register reads as zero, so only z is set out of reset.
    localparam flags_t FLAGS_RESET = 4'b0010;

endpackage

// File: rtl/alu_acc_pipe_if.sv
// Operand/opcode request and result/flag response bundle for alu_acc_pipe.
// Latency: n/a (wires only).
// Backpressure: none; the requester owns in_valid, the ALU owns out_valid.
interface alu_acc_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
    logic             acc_clr;
    logic             oe;
    logic             out_valid;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, sel, a, b, use_acc, acc_clr, oe,
        input  out_valid, c, z, n, v, acc
    );

    modport slave (
        input  in_valid, sel, a, b, use_acc, acc_clr, oe,
        output out_valid, c, z, n, v, acc
    );
endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: logic ops, add/sub with carry/borrow and signed overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] wide;
    logic           carry;
    logic           ovf;

    // Evaluate the opcode one bit wider so the carry/borrow falls out of the top bit.
    always_comb begin
        wide  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (sel)
            OP_ZERO: wide = '0;
            OP_AND:  wide = {1'b0, op_a & op_b};
            OP_OR:   wide = {1'b0, op_a | op_b};
            OP_ADD: begin
                wide  = {1'b0, op_a} + {1'b0, op_b};
                carry = wide[WIDTH];
                ovf   = (op_a[MSB] == op_b[MSB]) && (wide[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                // Top bit of the zero-extended difference is set exactly when A < B.
                wide  = {1'b0, op_a} - {1'b0, op_b};
                carry = wide[WIDTH];
                ovf   = (op_a[MSB] != op_b[MSB]) && (wide[MSB] != op_a[MSB]);
            end
            OP_XOR:  wide = {1'b0, op_a ^ op_b};
            OP_NOT:  wide = {1'b0, ~op_a};
            OP_ONES: wide = {1'b0, {WIDTH{1'b1}}};
            default: wide = '0;
        endcase
        result         = wide[WIDTH-1:0];
        flags          = '0;
        flags[FLAG_C]  = carry;
        flags[FLAG_Z]  = (wide[WIDTH-1:0] == '0);
        flags[FLAG_N]  = wide[MSB];
        flags[FLAG_V]  = ovf;
    end
endmodule

// File: rtl/alu_acc_pipe.sv
// Two-stage registered ALU with optional accumulator operand and tri-stated result bus.
// Latency: 2 cycles from accept edge to out_valid; 1 op/cycle.
// Backpressure: none; every accepted op emerges exactly once.
module alu_acc_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_acc_pipe_if.slave    bus,
    // Kept as a plain net because it joins the shared, multi-driver result bus.
    output wire [WIDTH-1:0]  y
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;

    logic [WIDTH-1:0] s1_res;
    flags_t           s1_flags;
    logic             s1_vld;

    logic [WIDTH-1:0] y_reg;
    flags_t           out_flags;
    logic             out_vld;

    logic [WIDTH-1:0] acc_q;

    // The accumulator reads its pre-edge value, so a same-cycle clear does not affect this op.
    assign op_a = bus.use_acc ? acc_q : bus.a;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_a   (op_a),
        .op_b   (bus.b),
        .sel    (bus.sel),
        .result (alu_res),
        .flags  (alu_flags)
    );

    // Stage 1: capture the ALU result on accept; data holds when idle, only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_res   <= '0;
            s1_flags <= FLAGS_RESET;
            s1_vld   <= 1'b0;
        end else begin
            s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                s1_res   <= alu_res;
                s1_flags <= alu_flags;
            end
        end
    end

    // Accumulator: clear wins over loading the accepted op's result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end else if (bus.in_valid) begin
            acc_q <= alu_res;
        end
    end

    // Stage 2: output registers follow stage 1 and hold their last value when it is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg     <= '0;
            out_flags <= FLAGS_RESET;
            out_vld   <= 1'b0;
        end else begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                y_reg     <= s1_res;
                out_flags <= s1_flags;
            end
        end
    end

    assign y             = bus.oe ? y_reg : {WIDTH{1'bz}};
    assign bus.out_valid = out_vld;
    assign bus.c         = out_flags[FLAG_C];
    assign bus.z         = out_flags[FLAG_Z];
    assign bus.n         = out_flags[FLAG_N];
    assign bus.v         = out_flags[FLAG_V];
    assign bus.acc       = acc_q;
endmodule

// File: tb/tb_alu_acc_pipe.sv
// Directed bench for alu_acc_pipe at WIDTH=8 and WIDTH=16.
// Latency: checks results two edges after the accept edge.
// Backpressure: none to exercise; stimulus runs on fixed cycle counts.
module tb_alu_acc_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_acc_pipe_if #(.WIDTH(8))  if8 ();
    alu_acc_pipe_if #(.WIDTH(16)) if16 ();
    wire [7:0]  y8;
    wire [15:0] y16;

    alu_acc_pipe #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave),
        .y   (y8)
    );

    alu_acc_pipe #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave),
        .y   (y16)
    );

    // Expected flags are written {c, z, n, v}.
    typedef struct {
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic [3:0]  f;
    } vec_t;

    vec_t v8  [12];
    vec_t v16 [10];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [2:0] s, input logic [15:0] a_, input logic [15:0] b_,
                                input logic [15:0] y_, input logic [3:0] f_);
        vec_t r;
        r.sel = s;
        r.a   = a_;
        r.b   = b_;
        r.y   = y_;
        r.f   = f_;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // A bus with no enabled driver reads as z in a 4-state simulator and as 0 in a 2-state one.
    task automatic chk_z8(input string nm, input logic [7:0] got);
        checks++;
        if (!((got === 8'hzz) || (got === 8'h00))) begin
            errors++;
            $display("FAIL %s: got %h, expected high-impedance", nm, got);
        end
    endtask

    task automatic chk_z16(input string nm, input logic [15:0] got);
        checks++;
        if (!((got === 16'hzzzz) || (got === 16'h0000))) begin
            errors++;
            $display("FAIL %s: got %h, expected high-impedance", nm, got);
        end
    endtask

    task automatic idle8();
        if8.in_valid = 1'b0;
        if8.sel      = OP_ZERO;
        if8.a        = '0;
        if8.b        = '0;
        if8.use_acc  = 1'b0;
        if8.acc_clr  = 1'b0;
        if8.oe       = 1'b1;
    endtask

    task automatic idle16();
        if16.in_valid = 1'b0;
        if16.sel      = OP_ZERO;
        if16.a        = '0;
        if16.b        = '0;
        if16.use_acc  = 1'b0;
        if16.acc_clr  = 1'b0;
        if16.oe       = 1'b1;
    endtask

    task automatic run_vec8(input vec_t t, input int i);
        if8.sel      = t.sel;
        if8.a        = t.a[7:0];
        if8.b        = t.b[7:0];
        if8.in_valid = 1'b1;
        step();
        if8.in_valid = 1'b0;
        step();
        chk($sformatf("w8[%0d] out_valid", i), {15'd0, if8.out_valid}, 16'd1);
        chk($sformatf("w8[%0d] y", i), {8'h00, y8}, t.y);
        chk($sformatf("w8[%0d] flags", i), {12'd0, if8.c, if8.z, if8.n, if8.v}, {12'd0, t.f});
        if8.oe = 1'b0;
        #1;
        chk_z8($sformatf("w8[%0d] y oe=0", i), y8);
        chk($sformatf("w8[%0d] flags oe=0", i), {12'd0, if8.c, if8.z, if8.n, if8.v}, {12'd0, t.f});
        if8.oe = 1'b1;
        step();
        chk($sformatf("w8[%0d] out_valid drop", i), {15'd0, if8.out_valid}, 16'd0);
        chk($sformatf("w8[%0d] y hold", i), {8'h00, y8}, t.y);
    endtask

    task automatic run_vec16(input vec_t t, input int i);
        if16.sel      = t.sel;
        if16.a        = t.a;
        if16.b        = t.b;
        if16.in_valid = 1'b1;
        step();
        if16.in_valid = 1'b0;
        step();
        chk($sformatf("w16[%0d] out_valid", i), {15'd0, if16.out_valid}, 16'd1);
        chk($sformatf("w16[%0d] y", i), y16, t.y);
        chk($sformatf("w16[%0d] flags", i), {12'd0, if16.c, if16.z, if16.n, if16.v}, {12'd0, t.f});
        if16.oe = 1'b0;
        #1;
        chk_z16($sformatf("w16[%0d] y oe=0", i), y16);
        chk($sformatf("w16[%0d] flags oe=0", i), {12'd0, if16.c, if16.z, if16.n, if16.v}, {12'd0, t.f});
        if16.oe = 1'b1;
        step();
        chk($sformatf("w16[%0d] out_valid drop", i), {15'd0, if16.out_valid}, 16'd0);
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, " y"}, {8'h00, y8}, 16'h0000);
        chk({tag, " flags"}, {12'd0, if8.c, if8.z, if8.n, if8.v}, 16'h0004);
        chk({tag, " out_valid"}, {15'd0, if8.out_valid}, 16'd0);
        chk({tag, " acc"}, {8'h00, if8.acc}, 16'h0000);
    endtask

    initial begin
        //                sel      a        b        y        c z n v
        v8[0]  = mk(OP_ADD,  16'hFF, 16'h01, 16'h00, 4'b1100);
        v8[1]  = mk(OP_SUB,  16'h4F, 16'h1F, 16'h30, 4'b0000);
        v8[2]  = mk(OP_SUB,  16'h1F, 16'h4F, 16'hD0, 4'b1010);
        v8[3]  = mk(OP_ADD,  16'h7F, 16'h01, 16'h80, 4'b0011);
        v8[4]  = mk(OP_AND,  16'h4F, 16'h1F, 16'h0F, 4'b0000);
        v8[5]  = mk(OP_ZERO, 16'h5A, 16'hA5, 16'h00, 4'b0100);
        v8[6]  = mk(OP_OR,   16'h50, 16'h0A, 16'h5A, 4'b0000);
        v8[7]  = mk(OP_XOR,  16'hF0, 16'h3C, 16'hCC, 4'b0010);
        v8[8]  = mk(OP_NOT,  16'h0F, 16'h33, 16'hF0, 4'b0010);
        v8[9]  = mk(OP_ONES, 16'h00, 16'h00, 16'hFF, 4'b0010);
        v8[10] = mk(OP_SUB,  16'h80, 16'h01, 16'h7F, 4'b0001);
        v8[11] = mk(OP_ADD,  16'h80, 16'h80, 16'h00, 4'b1101);

        v16[0] = mk(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
        v16[1] = mk(OP_SUB,  16'h1234, 16'h4321, 16'hCF13, 4'b1010);
        v16[2] = mk(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
        v16[3] = mk(OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
        v16[4] = mk(OP_OR,   16'h1200, 16'h0034, 16'h1234, 4'b0000);
        v16[5] = mk(OP_XOR,  16'hFFFF, 16'h00FF, 16'hFF00, 4'b0010);
        v16[6] = mk(OP_NOT,  16'h8000, 16'h0000, 16'h7FFF, 4'b0000);
        v16[7] = mk(OP_ZERO, 16'h1234, 16'h5678, 16'h0000, 4'b0100);
        v16[8] = mk(OP_ONES, 16'h0000, 16'h0000, 16'hFFFF, 4'b0010);
        v16[9] = mk(OP_SUB,  16'h4321, 16'h1234, 16'h30ED, 4'b0000);

        rst = 1'b1;
        idle8();
        idle16();
        @(negedge clk);
        @(negedge clk);
        chk_reset8("reset w8");
        chk("reset w16 flags", {12'd0, if16.c, if16.z, if16.n, if16.v}, 16'h0004);
        chk("reset w16 y", y16, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec8(v8[i], i);

        // Running sum: clear, then four chained accumulator adds with no bubble.
        if8.acc_clr = 1'b1;
        step();
        if8.acc_clr = 1'b0;
        chk("acc after clear", {8'h00, if8.acc}, 16'h0000);
        if8.sel      = OP_ADD;
        if8.use_acc  = 1'b1;
        if8.a        = 8'hAA;
        if8.b        = 8'h05;
        if8.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("accum acc[%0d]", i), {8'h00, if8.acc}, 16'(5 * (i + 1)));
            if (i > 0) begin
                chk($sformatf("accum y[%0d]", i), {8'h00, y8}, 16'(5 * i));
                chk($sformatf("accum out_valid[%0d]", i), {15'd0, if8.out_valid}, 16'd1);
            end
        end
        if8.in_valid = 1'b0;
        step();
        chk("accum y last", {8'h00, y8}, 16'h0014);
        chk("accum acc last", {8'h00, if8.acc}, 16'h0014);

        // Clear wins over the load, but the op still reads the pre-clear 20.
        if8.b        = 8'h01;
        if8.acc_clr  = 1'b1;
        if8.in_valid = 1'b1;
        step();
        idle8();
        chk("clr priority acc", {8'h00, if8.acc}, 16'h0000);
        step();
        chk("clr priority y", {8'h00, y8}, 16'h0015);
        chk("clr priority out_valid", {15'd0, if8.out_valid}, 16'd1);

        // Reset with one op in the output stage and another in stage 1.
        idle8();
        if8.sel      = OP_ADD;
        if8.a        = 8'h10;
        if8.b        = 8'h01;
        if8.in_valid = 1'b1;
        step();
        if8.a = 8'h20;
        if8.b = 8'h02;
        step();
        if8.in_valid = 1'b0;
        chk("inflight y before rst", {8'h00, y8}, 16'h0011);
        chk("inflight acc before rst", {8'h00, if8.acc}, 16'h0022);
        #2 rst = 1'b1;
        #1;
        chk_reset8("mid rst");
        @(negedge clk);
        rst = 1'b0;
        chk("post rst out_valid 0", {15'd0, if8.out_valid}, 16'd0);
        step();
        chk("post rst out_valid 1", {15'd0, if8.out_valid}, 16'd0);
        if8.sel      = OP_ADD;
        if8.a        = 8'h03;
        if8.b        = 8'h04;
        if8.in_valid = 1'b1;
        step();
        if8.in_valid = 1'b0;
        step();
        chk("first op after rst y", {8'h00, y8}, 16'h0007);
        chk("first op after rst out_valid", {15'd0, if8.out_valid}, 16'd1);

        for (int i = 0; i < 10; i++) run_vec16(v16[i], i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_acc_pipe.md
# alu_acc_pipe

Parametrised, registered successor to the team's 8-bit enabled ALU. Takes a WIDTH-bit operand pair plus a 3-bit opcode and produces a registered result with status flags two cycles later. Can substitute an internal accumulator for operand A, giving running-sum and running-logic sequences. Sits on the datapath between the operand register file and the shared result bus, which it drives through a tri-state output enable.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/opcode qualifier; one op accepted per cycle when high
- sel  in  3  opcode
- a, b  in  WIDTH  operands
- use_acc  in  1  when high, accumulator replaces a
- acc_clr  in  1  synchronous accumulator clear
- oe  in  1  output enable for y
- y  out  WIDTH  registered result; high-impedance when oe=0
- out_valid  out  1  result/flags qualifier
- c, z, n, v  out  1 each  carry/borrow, zero, negative (MSB), signed overflow
- acc  out  WIDTH  current accumulator value (always driven)

## Operation
- Opcodes: 000 all-zero; 001 A&B; 010 A|B; 011 A+B; 100 A−B; 101 A^B; 110 ~A; 111 all-ones. A = use_acc ? acc : a.
- Arithmetic in WIDTH+1 bits. ADD: c = carry-out. SUB: c = borrow (1 iff A<B unsigned), result = A+~B+1 truncated.
- v: ADD: operands same sign and result sign differs. SUB: operands differ in sign and result sign differs from A. v=0 and c=0 for all non-arithmetic opcodes.
- z = (result == 0); n = result[WIDTH-1]; both valid for every opcode.
- Stage 1 (accept cycle, in_valid=1): compute result and flags combinationally, register into s1 (result, flags, valid). Accumulator loads the result at the same edge.
- Stage 2: s1 copied to output registers y/c/z/n/v; out_valid = s1 valid.
- acc_clr=1: accumulator ← 0 at the edge, with priority over an accepted op's load. The op itself still proceeds. If use_acc=1 in the same cycle, it reads the pre-clear value.
- in_valid=0: stage 1 valid clears. Accumulator holds. Output data registers hold their last value; only out_valid drops.
- y = oe ? y_reg : all-Z, combinational. Flags, out_valid and acc are never tri-stated.
- No back-pressure: every accepted op emerges exactly once.

## Timing
- Latency 2 cycles: op accepted at edge k appears with out_valid at edge k+1 and is visible through cycle k+1→k+2.
- Throughput 1 op/cycle.
- Back-to-back use_acc ops chain with no bubble. The accumulator updates at the accept edge, so the next cycle's op sees it.
- oe→y is combinational, with zero-cycle effect.
- Reset (asynchronous, any time, including mid-pipeline): y_reg, s1 result, acc = 0; c, v, n = 0; z = 1; out_valid = 0; s1 valid = 0. In-flight ops are discarded. The first op after reset deassertion is accepted at the first following edge.

## Structure
- Package alu_pkg: opcode localparams (OP_ZERO … OP_ONES), flag bit-index constants.
- Sub-module alu_core (combinational, WIDTH-parametrised): A, B, sel → result, c, z, n, v.
- alu_acc_pipe holds the operand mux, accumulator, stage registers and tri-state driver.

## Test plan
- Reset, then WIDTH=8, ADD a=0xFF b=0x01 → two edges later y=0x00, c=1, z=1, v=0, out_valid 1 for one cycle.
- SUB a=0x4F b=0x1F → y=0x30, c=0. Then SUB a=0x1F b=0x4F → y=0xD0, c=1, n=1.
- ADD a=0x7F b=0x01 → y=0x80, v=1, n=1. Then AND a=0x4F b=0x1F → y=0x0F, c=v=0.
- Accumulate: acc_clr pulse, then four consecutive ADD use_acc=1 with b=5 → y=5,10,15,20 on consecutive cycles; acc=20 after the last.
- Sweep all 8 opcodes with oe toggled: y=Z while oe=0 and flags unaffected; values match the opcode list at WIDTH=8 and WIDTH=16.
- Assert rst mid-stream with two ops in flight → outputs reach reset values immediately, no out_valid for the dropped ops, acc=0.
